// File: rtl/mcs51_port_if.sv
// SFR-side bus of one mcs51 I/O port: byte/bit latch writes and CPU read-back.
interface mcs51_port_if;
  logic       sfr_wr_en;
  logic [7:0] sfr_wr_data;
  logic       bit_wr_en;
  logic [2:0] bit_idx;
  logic       bit_wr_val;
  logic       rmw;
  logic [7:0] rd_data;

  modport master (
    output sfr_wr_en, sfr_wr_data, bit_wr_en, bit_idx, bit_wr_val, rmw,
    input  rd_data
  );

  modport slave (
    input  sfr_wr_en, sfr_wr_data, bit_wr_en, bit_idx, bit_wr_val, rmw,
    output rd_data
  );
endinterface

// File: rtl/mcs51_port.sv
// One 8-bit quasi-bidirectional mcs51 port: SFR latch, pin synchroniser, read mux, pin drive.
// Define MCS51_PORT_PULLUP_PULSE_EN to add the strong-pullup pulse on 0->1 latch transitions.
module mcs51_port #(
  parameter logic [7:0]  RESET_VAL    = 8'hFF,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned PULSE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  mcs51_port_if.slave sfr,
  input  logic [7:0] pin_in,
  output logic [7:0] pin_sync,
  output logic [7:0] pin_out,
  output logic [7:0] pin_oe
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("mcs51_port: SYNC_STAGES must be in 2..4");
  end
  if (PULSE_CYCLES < 1 || PULSE_CYCLES > 15) begin : g_bad_pulse_cycles
    $error("mcs51_port: PULSE_CYCLES must be in 1..15");
  end

  logic [7:0] latch;
  logic [7:0] latch_next;
  logic [7:0] sync_q [SYNC_STAGES];

  // Byte write outranks a coincident bit write.
  always_comb begin
    latch_next = latch;
    if (sfr.sfr_wr_en)
      latch_next = sfr.sfr_wr_data;
    else if (sfr.bit_wr_en)
      latch_next[sfr.bit_idx] = sfr.bit_wr_val;
  end

  always_ff @(posedge clk) begin
    if (reset)
      latch <= RESET_VAL;
    else
      latch <= latch_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '1;
    end else begin
      sync_q[0] <= pin_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign pin_sync    = sync_q[SYNC_STAGES-1];
  assign sfr.rd_data = sfr.rmw ? latch : pin_sync;
  assign pin_out     = latch;

`ifdef MCS51_PORT_PULLUP_PULSE_EN
  localparam int unsigned CW = $clog2(PULSE_CYCLES + 1);

  logic [CW-1:0] cnt [8];
  logic [7:0]    pulse_active;

  // Edges are detected against latch_next so the pulse starts with the write itself.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 8; i++) begin
      if (reset)
        cnt[i] <= '0;
      else if (!latch[i] && latch_next[i])
        cnt[i] <= CW'(PULSE_CYCLES);
      else if (latch[i] && !latch_next[i])
        cnt[i] <= '0;
      else if (cnt[i] != '0)
        cnt[i] <= cnt[i] - CW'(1);
    end
  end

  always_comb begin
    pulse_active = '0;
    for (int unsigned i = 0; i < 8; i++)
      pulse_active[i] = (cnt[i] != '0);
  end

  assign pin_oe = ~latch | pulse_active;
`else
  assign pin_oe = ~latch;
`endif

endmodule

// File: tb/tb_mcs51_port.sv
// Bench for mcs51_port: directed vector table, RMW sequence, then random traffic vs a model.
module tb_mcs51_port;

  localparam int unsigned SS = 2;
  localparam int unsigned PC = 2;
`ifdef MCS51_PORT_PULLUP_PULSE_EN
  localparam bit PULSE_ON = 1'b1;
`else
  localparam bit PULSE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pin_in, pin_sync, pin_out, pin_oe;

  mcs51_port_if bus ();

  mcs51_port #(.RESET_VAL(8'hFF), .SYNC_STAGES(SS), .PULSE_CYCLES(PC)) dut (
    .clk     (clk),
    .reset   (reset),
    .sfr     (bus),
    .pin_in  (pin_in),
    .pin_sync(pin_sync),
    .pin_out (pin_out),
    .pin_oe  (pin_oe)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit         rst;
    bit         wr;
    logic [7:0] wdata;
    bit         bwr;
    logic [2:0] bidx;
    bit         bval;
    bit         rmw;
    logic [7:0] pin;
    logic [7:0] e_out;
    logic [7:0] e_oe_off;
    logic [7:0] e_oe_on;
    logic [7:0] e_sync;
    logic [7:0] e_rd;
  } vec_t;

  vec_t tv[$];

  task automatic drive(input bit rst, input bit wr, input logic [7:0] wdata, input bit bwr,
                       input logic [2:0] bidx, input bit bval, input bit rmw, input logic [7:0] pin);
    reset           = rst;
    bus.sfr_wr_en   = wr;
    bus.sfr_wr_data = wdata;
    bus.bit_wr_en   = bwr;
    bus.bit_idx     = bidx;
    bus.bit_wr_val  = bval;
    bus.rmw         = rmw;
    pin_in          = pin;
  endtask

  // Reference model: port state expressed as latch byte, remaining pulse cycles per pin,
  // and a history queue of sampled pin bytes whose oldest entry is what the CPU sees.
  logic [7:0] m_latch;
  int         m_pulse [8];
  logic [7:0] m_hist[$];

  task automatic model_edge(input bit rst, input bit wr, input logic [7:0] wdata, input bit bwr,
                            input logic [2:0] bidx, input bit bval, input logic [7:0] pin);
    logic [7:0] nxt;
    if (rst) begin
      m_latch = 8'hFF;
      foreach (m_pulse[i]) m_pulse[i] = 0;
      m_hist.delete();
      for (int k = 0; k < SS; k++) m_hist.push_back(8'hFF);
      return;
    end
    nxt = m_latch;
    if (wr) nxt = wdata;
    else if (bwr) nxt[bidx] = bval;
    for (int i = 0; i < 8; i++) begin
      if (!m_latch[i] && nxt[i])      m_pulse[i] = PC;
      else if (m_latch[i] && !nxt[i]) m_pulse[i] = 0;
      else if (m_pulse[i] > 0)        m_pulse[i] = m_pulse[i] - 1;
    end
    m_latch = nxt;
    m_hist.push_back(pin);
    void'(m_hist.pop_front());
  endtask

  function automatic logic [7:0] model_oe();
    logic [7:0] oe = ~m_latch;
    if (PULSE_ON)
      for (int i = 0; i < 8; i++) if (m_pulse[i] > 0) oe[i] = 1'b1;
    return oe;
  endfunction

  initial begin
    logic [7:0] rd_tmp;

    //      rst wr wdata  bwr idx val rmw pin     out    oe_off oe_on  sync   rd
    tv.push_back('{1, 0, 8'h00, 0, 0, 0, 0, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF});
    tv.push_back('{1, 0, 8'h00, 0, 0, 0, 0, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF});
    tv.push_back('{1, 0, 8'h00, 0, 0, 0, 0, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF});
    tv.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF});
    tv.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 8'h55, 8'hFF, 8'h00, 8'h00, 8'h55, 8'h55});
    tv.push_back('{0, 1, 8'h8A, 0, 0, 0, 1, 8'h55, 8'h8A, 8'h75, 8'h75, 8'h55, 8'h8A});
    tv.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 8'h55, 8'h8A, 8'h75, 8'h75, 8'h55, 8'h55});
    tv.push_back('{0, 1, 8'hFF, 0, 0, 0, 1, 8'h55, 8'hFF, 8'h00, 8'h75, 8'h55, 8'hFF});
    tv.push_back('{0, 0, 8'h00, 0, 0, 0, 1, 8'h55, 8'hFF, 8'h00, 8'h75, 8'h55, 8'hFF});
    tv.push_back('{0, 0, 8'h00, 0, 0, 0, 1, 8'h55, 8'hFF, 8'h00, 8'h00, 8'h55, 8'hFF});
    tv.push_back('{0, 1, 8'hFF, 0, 0, 0, 1, 8'h55, 8'hFF, 8'h00, 8'h00, 8'h55, 8'hFF});
    tv.push_back('{0, 0, 8'h00, 1, 3, 0, 1, 8'h55, 8'hF7, 8'h08, 8'h08, 8'h55, 8'hF7});
    tv.push_back('{0, 1, 8'h00, 1, 0, 1, 1, 8'h55, 8'h00, 8'hFF, 8'hFF, 8'h55, 8'h00});
    tv.push_back('{0, 1, 8'h01, 0, 0, 0, 1, 8'h55, 8'h01, 8'hFE, 8'hFF, 8'h55, 8'h01});
    tv.push_back('{0, 0, 8'h00, 0, 0, 0, 1, 8'h55, 8'h01, 8'hFE, 8'hFF, 8'h55, 8'h01});
    tv.push_back('{0, 0, 8'h00, 0, 0, 0, 1, 8'h55, 8'h01, 8'hFE, 8'hFE, 8'h55, 8'h01});
    tv.push_back('{0, 1, 8'h01, 0, 0, 0, 1, 8'h55, 8'h01, 8'hFE, 8'hFE, 8'h55, 8'h01});
    tv.push_back('{0, 0, 8'h00, 0, 0, 0, 1, 8'h55, 8'h01, 8'hFE, 8'hFE, 8'h55, 8'h01});
    tv.push_back('{0, 1, 8'h00, 0, 0, 0, 1, 8'h55, 8'h00, 8'hFF, 8'hFF, 8'h55, 8'h00});
    tv.push_back('{0, 1, 8'h01, 0, 0, 0, 1, 8'h55, 8'h01, 8'hFE, 8'hFF, 8'h55, 8'h01});
    tv.push_back('{1, 1, 8'h00, 0, 0, 0, 1, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF});
    tv.push_back('{0, 0, 8'h00, 0, 0, 0, 1, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF});
    tv.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 8'h55, 8'hFF, 8'h00, 8'h00, 8'h55, 8'h55});

    drive(1, 0, 8'h00, 0, 0, 0, 0, 8'h55);
    foreach (tv[k]) begin
      drive(tv[k].rst, tv[k].wr, tv[k].wdata, tv[k].bwr, tv[k].bidx, tv[k].bval, tv[k].rmw, tv[k].pin);
      @(posedge clk); #1;
      check($sformatf("v%0d pin_out", k),  pin_out,     tv[k].e_out);
      check($sformatf("v%0d pin_oe", k),   pin_oe,      PULSE_ON ? tv[k].e_oe_on : tv[k].e_oe_off);
      check($sformatf("v%0d pin_sync", k), pin_sync,    tv[k].e_sync);
      check($sformatf("v%0d rd_data", k),  bus.rd_data, tv[k].e_rd);
    end

    // Read-modify-write emulation: the write-back must use the latch, not the pins.
    drive(0, 0, 8'h00, 0, 0, 0, 1, 8'h55);
    #1;
    rd_tmp = bus.rd_data;
    check("rmw_read_latch", rd_tmp, 8'hFF);
    drive(0, 1, rd_tmp & 8'h8A, 0, 0, 0, 1, 8'h55);
    @(posedge clk); #1;
    check("rmw_writeback_pin_out", pin_out, 8'h8A);
    check("rmw_after_write_rd", bus.rd_data, 8'h8A);
    drive(0, 0, 8'h00, 0, 0, 0, 0, 8'h55);
    #1;
    check("plain_read_pins", bus.rd_data, 8'h55);

    // Random traffic against the model, starting from a reset.
    for (int n = 0; n < 600; n++) begin
      bit         r_rst, r_wr, r_bwr, r_bval, r_rmw;
      logic [7:0] r_wdata, r_pin;
      logic [2:0] r_bidx;
      r_rst   = (n == 0) || ($urandom_range(0, 59) == 0);
      r_wr    = ($urandom_range(0, 3) == 0);
      r_wdata = 8'($urandom);
      r_bwr   = ($urandom_range(0, 2) == 0);
      r_bidx  = 3'($urandom);
      r_bval  = 1'($urandom);
      r_rmw   = 1'($urandom);
      r_pin   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : pin_in;
      drive(r_rst, r_wr, r_wdata, r_bwr, r_bidx, r_bval, r_rmw, r_pin);
      @(posedge clk);
      model_edge(r_rst, r_wr, r_wdata, r_bwr, r_bidx, r_bval, r_pin);
      #1;
      check("rand pin_out",  pin_out,     m_latch);
      check("rand pin_oe",   pin_oe,      model_oe());
      check("rand pin_sync", pin_sync,    m_hist[0]);
      check("rand rd_data",  bus.rd_data, r_rmw ? m_latch : m_hist[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
